// File: rtl/regfile_arbiter.sv
// regfile_arbiter: round-robin write/read arbiter and sequencer for a single-access register file.
// The file writes on every clock with rf_rwen low, so rf_rwen is held high except in a granted write.
module regfile_arbiter #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_req,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    output logic              wr_gnt,
    input  logic              rd_req,
    input  logic [ADDR_W-1:0] rd_addr1,
    input  logic [ADDR_W-1:0] rd_addr2,
    output logic              rd_gnt,
    output logic              rd_valid,
    output logic [DATA_W-1:0] rd_data1,
    output logic [DATA_W-1:0] rd_data2,
    output logic              rf_rwen,
    output logic [ADDR_W-1:0] rf_raddr1,
    output logic [ADDR_W-1:0] rf_raddr2,
    output logic [ADDR_W-1:0] rf_waddr,
    output logic [DATA_W-1:0] rf_wdata,
    input  logic [DATA_W-1:0] rf_rdata1,
    input  logic [DATA_W-1:0] rf_rdata2
);
    typedef enum logic [1:0] {IDLE, WRITE, READ, RDATA} state_t;
    state_t state, state_nx;
    logic   last_rd, gw, gr;
    always_comb begin
        gw       = (state == IDLE) && wr_req && (!rd_req || last_rd);
        gr       = (state == IDLE) && rd_req && !gw;
        state_nx = gw ? WRITE : gr ? READ : (state == READ) ? RDATA : IDLE;
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            last_rd   <= 1'b1;
            rd_valid  <= 1'b0;
            rd_data1  <= '0;
            rd_data2  <= '0;
            rf_raddr1 <= '0;
            rf_raddr2 <= '0;
            rf_waddr  <= '0;
            rf_wdata  <= '0;
        end else begin
            state    <= state_nx;
            rd_valid <= (state == RDATA);
            if (gw) begin
                rf_waddr <= wr_addr;
                rf_wdata <= wr_data;
                last_rd  <= 1'b0;
            end
            if (gr) begin
                rf_raddr1 <= rd_addr1;
                rf_raddr2 <= rd_addr2;
                last_rd   <= 1'b1;
            end
            if (state == RDATA) begin
                rd_data1 <= rf_rdata1;
                rd_data2 <= rf_rdata2;
            end
        end
    end
    // Reset overrides the enable so a write in progress is aborted immediately.
    assign wr_gnt  = (state == WRITE) && !rst;
    assign rd_gnt  = (state == READ) && !rst;
    assign rf_rwen = (state != WRITE) || rst;
endmodule

// File: tb/tb_regfile_arbiter.sv
// tb_regfile_arbiter: directed and random checks of regfile_arbiter against a transaction-level model.
// A behavioural register file is attached so read-after-write data can be verified end to end.
module tb_regfile_arbiter;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        wr_req = 1'b0, rd_req = 1'b0;
    logic [4:0]  wr_addr = '0, rd_addr1 = '0, rd_addr2 = '0;
    logic [31:0] wr_data = '0;
    logic        wr_gnt, rd_gnt, rd_valid, rf_rwen;
    logic [31:0] rd_data1, rd_data2, rf_wdata;
    logic [4:0]  rf_raddr1, rf_raddr2, rf_waddr;
    logic [31:0] rf_rdata1 = '0, rf_rdata2 = '0;

    regfile_arbiter #(.DATA_W(32), .ADDR_W(5)) dut (
        .clk(clk), .rst(rst),
        .wr_req(wr_req), .wr_addr(wr_addr), .wr_data(wr_data), .wr_gnt(wr_gnt),
        .rd_req(rd_req), .rd_addr1(rd_addr1), .rd_addr2(rd_addr2), .rd_gnt(rd_gnt),
        .rd_valid(rd_valid), .rd_data1(rd_data1), .rd_data2(rd_data2),
        .rf_rwen(rf_rwen), .rf_raddr1(rf_raddr1), .rf_raddr2(rf_raddr2),
        .rf_waddr(rf_waddr), .rf_wdata(rf_wdata), .rf_rdata1(rf_rdata1), .rf_rdata2(rf_rdata2)
    );

    always #5 clk = ~clk;

    // Register file: writes whenever rf_rwen is low, otherwise registers both read ports.
    logic [31:0] mem [32];
    bit          init_done = 1'b0;
    always @(posedge clk) begin
        if (!init_done) begin
            for (int i = 0; i < 32; i++) mem[i] <= '0;
        end else if (!rf_rwen) begin
            mem[rf_waddr] <= rf_wdata;
        end else begin
            rf_rdata1 <= mem[rf_raddr1];
            rf_rdata2 <= mem[rf_raddr2];
        end
    end

    int          n_chk = 0, n_fail = 0, cyc = 0;
    int          free_at = 0, wg_at = -1, rg_at = -1, rv_at = -1, lg = 0;
    bit          last_rd = 1'b1, ewg, erg, erv;
    logic [4:0]  wa, ra1, ra2;
    logic [31:0] wd, cap1, cap2, ed1 = '0, ed2 = '0;
    logic [31:0] ref_mem [32];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s cycle %0d: got %h expected %h", tag, cyc, got, exp);
        end
    endtask

    // Model: a sampled request occupies the file for 2 (write) or 3 (read) cycles from the sample.
    task automatic step();
        if (rst) begin
            free_at = cyc + 1; wg_at = -1; rg_at = -1; rv_at = -1;
            last_rd = 1'b1; ed1 = '0; ed2 = '0;
        end else begin
            if (wg_at == cyc) ref_mem[wa] = wd;
            if (rg_at == cyc) begin cap1 = ref_mem[ra1]; cap2 = ref_mem[ra2]; end
            if (cyc >= free_at && (wr_req || rd_req)) begin
                if (wr_req && (!rd_req || last_rd)) begin
                    wg_at = cyc + 1; free_at = cyc + 2; wa = wr_addr; wd = wr_data; last_rd = 1'b0;
                end else begin
                    rg_at = cyc + 1; rv_at = cyc + 3; free_at = cyc + 3;
                    ra1 = rd_addr1; ra2 = rd_addr2; last_rd = 1'b1;
                end
            end
        end
        @(posedge clk); #1;
        cyc++;
        init_done = 1'b1;
        ewg = (wg_at == cyc);
        erg = (rg_at == cyc);
        erv = (rv_at == cyc);
        if (erv) begin ed1 = cap1; ed2 = cap2; end
        chk("wr_gnt", 32'(wr_gnt), 32'(ewg));
        chk("rd_gnt", 32'(rd_gnt), 32'(erg));
        chk("rd_valid", 32'(rd_valid), 32'(erv));
        chk("rf_rwen", 32'(rf_rwen), 32'(!ewg));
        chk("rd_data1", rd_data1, ed1);
        chk("rd_data2", rd_data2, ed2);
        if (ewg) begin
            chk("rf_waddr", 32'(rf_waddr), 32'(wa));
            chk("rf_wdata", rf_wdata, wd);
        end
        if (erg) begin
            chk("rf_raddr1", 32'(rf_raddr1), 32'(ra1));
            chk("rf_raddr2", 32'(rf_raddr2), 32'(ra2));
        end
    endtask

    initial begin
        for (int i = 0; i < 32; i++) ref_mem[i] = '0;
        // Reset with both requests active
        wr_req = 1'b1; rd_req = 1'b1; wr_addr = 5'd3; wr_data = 32'h1111_1111;
        step(); step();
        chk("rst_waddr", 32'(rf_waddr), 0);
        chk("rst_wdata", rf_wdata, 0);
        chk("rst_raddr1", 32'(rf_raddr1), 0);
        chk("rst_raddr2", 32'(rf_raddr2), 0);
        rst = 1'b0; wr_req = 1'b0; rd_req = 1'b0;
        step();
        // Single write, then a second write
        wr_req = 1'b1; wr_addr = 5'd5; wr_data = 32'h1234_5678;
        step();
        chk("w1_gnt", 32'(wr_gnt), 1);
        chk("w1_addr", 32'(rf_waddr), 5);
        wr_req = 1'b0;
        step();
        chk("w1_rwen_after", 32'(rf_rwen), 1);
        wr_req = 1'b1; wr_addr = 5'd15; wr_data = 32'hABCD_ABCD;
        step();
        wr_req = 1'b0;
        step();
        // Read-back
        rd_req = 1'b1; rd_addr1 = 5'd5; rd_addr2 = 5'd15;
        step();
        chk("rb_gnt", 32'(rd_gnt), 1);
        rd_req = 1'b0;
        step(); step();
        chk("rb_valid", 32'(rd_valid), 1);
        chk("rb_d1", rd_data1, 32'h1234_5678);
        chk("rb_d2", rd_data2, 32'hABCD_ABCD);
        // Tie after reset: write first
        rst = 1'b1; step(); rst = 1'b0;
        wr_req = 1'b1; wr_addr = 5'd7; wr_data = 32'h0000_00A5;
        rd_req = 1'b1; rd_addr1 = 5'd7; rd_addr2 = 5'd5;
        step();
        chk("tie_w", 32'(wr_gnt), 1);
        wr_req = 1'b0;
        step(); step();
        chk("tie_r", 32'(rd_gnt), 1);
        rd_req = 1'b0;
        step(); step();
        chk("tie_d1", rd_data1, 32'h0000_00A5);
        chk("tie_d2", rd_data2, 32'h1234_5678);
        // Sustained contention
        wr_req = 1'b1; rd_req = 1'b1; lg = 0;
        wr_addr = 5'(16 + $urandom_range(0, 15)); wr_data = $urandom;
        for (int i = 0; i < 12; i++) begin
            step();
            if (wr_gnt) begin
                if (lg != 0) chk("alt_w", lg, 2);
                lg = 1;
                wr_addr = 5'(16 + $urandom_range(0, 15)); wr_data = $urandom;
            end
            if (rd_gnt) begin
                if (lg != 0) chk("alt_r", lg, 1);
                lg = 2;
                rd_addr1 = 5'($urandom); rd_addr2 = 5'($urandom);
            end
        end
        wr_req = 1'b0; rd_req = 1'b0;
        step(); step(); step();
        // Reset during WRITE aborts the write
        wr_req = 1'b1; wr_addr = 5'd5; wr_data = 32'hDEAD_BEEF;
        step();
        chk("rw_gnt", 32'(wr_gnt), 1);
        rst = 1'b1; wr_req = 1'b0;
        #1 chk("rw_rwen", 32'(rf_rwen), 1);
        step();
        rst = 1'b0;
        step();
        rd_req = 1'b1; rd_addr1 = 5'd5; rd_addr2 = 5'd5;
        step();
        rd_req = 1'b0;
        step(); step();
        chk("rw_d1", rd_data1, 32'h1234_5678);
        // Reset during RDATA suppresses rd_valid
        rd_req = 1'b1; rd_addr1 = 5'd15;
        step();
        rd_req = 1'b0;
        step();
        rst = 1'b1;
        step();
        chk("rr_novalid", 32'(rd_valid), 0);
        rst = 1'b0;
        step();
        chk("rr_novalid2", 32'(rd_valid), 0);
        // Random traffic with occasional reset
        for (int i = 0; i < 400; i++) begin
            rst = ($urandom_range(0, 49) == 0);
            step();
            if (ewg || !wr_req) begin
                wr_req = 1'($urandom); wr_addr = 5'($urandom_range(0, 7)); wr_data = $urandom;
            end
            if (erg || !rd_req) begin
                rd_req = 1'($urandom);
                rd_addr1 = 5'($urandom_range(0, 7)); rd_addr2 = 5'($urandom_range(0, 7));
            end
        end
        rst = 1'b0; wr_req = 1'b0; rd_req = 1'b0;
        step(); step(); step();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
